bit_serial_subtractor: RTL

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor.sv | 106 ++++++++++
 1 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial n-bit subtractor: one full-subtractor step per clock, LSB first.
// Result and final borrow are published on the edge that processes the MSB.
module bit_serial_subtractor #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] d,
   output logic         bout
);

   localparam int cw = $clog2(n) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [n-1:0]  sa;
   logic [n-1:0]  sb;
   logic [n-1:0]  res;
   logic          br;
   logic [cw-1:0] cnt;

   logic ak;
   logic bk;
   logic dbit;
   logic nbr;
   logic accept;
   logic last;

   assign ak   = sa[0];
   assign bk   = sb[0];
   assign dbit = ak ^ bk ^ br;
   assign nbr  = (~ak & bk) | (~(ak ^ bk) & br);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            last = (cnt == cw'(n - 1));
            if (last) state_d = DONE;
         end
         DONE: begin
            accept  = start;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // start is only honoured via accept, so a/b/start are ignored in RUN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         d    <= '0;
         bout <= 1'b0;
      end else if (accept) begin
         sa  <= a;
         sb  <= b;
         res <= '0;
         br  <= 1'b0;
         cnt <= '0;
      end else if (state_q == RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         res <= {dbit, res[n-1:1]};
         br  <= nbr;
         cnt <= cnt + cw'(1);
         if (last) begin
            d    <= {dbit, res[n-1:1]};
            bout <= nbr;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
